// File: rtl/ex_mem_reg_pkg.sv
// Shared widths and field bundles for the EX/MEM stage and the MEM/WB stage that mirrors it.
package ex_mem_reg_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  // Control bits that must be squashed by a flush; the data bundle may keep stale values.
  typedef struct packed {
    logic mem_write;
    logic mem_read;
    logic reg_write;
    logic halt;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] xout;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] pc_inc;
    logic [REG_W-1:0]  write_reg;
    logic              mem_to_reg;
  } ex_mem_data_t;

endpackage

// File: rtl/ex_mem_reg_pipe_field_reg.sv
// Field-group flop: async reset, clear-to-zero, and a hold enable. Clear wins over hold.
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: stall hold, flush-to-bubble, sticky halt with one-shot dump, sticky error.
// Priority on every edge is flush, then stall, then load; stall is a hold, not a handshake.
module ex_mem_reg #(
  parameter int DATA_W = ex_mem_reg_pkg::DATA_W,
  parameter int REG_W  = ex_mem_reg_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_XOut,
  input  logic [DATA_W-1:0] ex_WriteData,
  input  logic              ex_MemWrite,
  input  logic              ex_MemRead,
  input  logic              ex_RegWrite,
  input  logic [REG_W-1:0]  ex_WriteReg,
  input  logic              ex_MemToReg,
  input  logic [DATA_W-1:0] ex_PCInc,
  input  logic              ex_halt,
  input  logic              ex_err,
  output logic [DATA_W-1:0] XOut,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  output logic              createdump,
  output logic              RegWrite,
  output logic [REG_W-1:0]  WriteReg,
  output logic              MemToReg,
  output logic [DATA_W-1:0] PCInc,
  output logic              valid,
  output logic              halted,
  output logic              err
);

  import ex_mem_reg_pkg::*;

  localparam int DW = 3 * DATA_W + REG_W + 1;

  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;
  ex_mem_ctrl_t  ctrl_d;
  ex_mem_ctrl_t  ctrl_q;
  logic          dumped;

  assign data_d = {ex_XOut, ex_WriteData, ex_PCInc, ex_WriteReg, ex_MemToReg};

  always_comb begin
    ctrl_d           = '0;
    ctrl_d.mem_write = ex_MemWrite;
    ctrl_d.mem_read  = ex_MemRead;
    ctrl_d.reg_write = ex_RegWrite;
    ctrl_d.halt      = ex_halt;
  end

  pipe_field_reg #(.W(DW)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (~stall),
    .clr (flush),
    .d   (data_d),
    .q   (data_q)
  );

  pipe_field_reg #(.W($bits(ex_mem_ctrl_t))) u_ctrl (
    .clk (clk),
    .rst (rst),
    .en  (~stall),
    .clr (flush),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  assign {XOut, WriteData, PCInc, WriteReg, MemToReg} = data_q;

  assign MemWrite   = ctrl_q.mem_write & valid;
  assign MemRead    = ctrl_q.mem_read  & valid;
  assign RegWrite   = ctrl_q.reg_write & valid;
  // The dump request waits out any stall so memory sees it exactly once.
  assign createdump = valid & ctrl_q.halt & ~stall & ~dumped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      halted <= 1'b0;
      err    <= 1'b0;
      dumped <= 1'b0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (!stall) begin
        // Once halted, everything behind the HALT enters as a bubble.
        valid <= ex_valid & ~halted;
        if (ex_valid && ex_halt && !halted) halted <= 1'b1;
        if (ex_valid && ex_err)             err    <= 1'b1;
      end
      if (createdump) dumped <= 1'b1;
    end
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register that sits directly upstream of the memory stage.
- Captures execute-stage results and control each cycle, and presents them to the memory stage: address, store data, MemWrite, MemRead, createdump.
- Also carries writeback control onward.
- Implements stall hold, flush-to-bubble, halt tracking with a one-shot dump pulse, and a sticky error flag.

Parameters:
- DATA_W, 16, width of address/ALU result, store data and PC.
- REG_W, 3, register-file index width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all fields this cycle
- flush  in  1  replace the captured entry with a bubble
- ex_valid  in  1  execute stage holds a real instruction
- ex_XOut  in  DATA_W  ALU result / memory address
- ex_WriteData  in  DATA_W  store data
- ex_MemWrite  in  1  store
- ex_MemRead  in  1  load
- ex_RegWrite  in  1  writes the register file
- ex_WriteReg  in  REG_W  destination register
- ex_MemToReg  in  1  writeback selects memory data
- ex_PCInc  in  DATA_W  PC+2 for link writeback
- ex_halt  in  1  instruction is HALT
- ex_err  in  1  error raised upstream
- XOut  out  DATA_W  to memory stage
- WriteData  out  DATA_W  to memory stage
- MemWrite  out  1  to memory stage, gated by valid
- MemRead  out  1  to memory stage, gated by valid
- createdump  out  1  one-cycle dump request to memory stage
- RegWrite  out  1  gated by valid
- WriteReg  out  REG_W
- MemToReg  out  1
- PCInc  out  DATA_W
- valid  out  1  stage holds a real instruction
- halted  out  1  HALT has entered this stage; sticky
- err  out  1  sticky error

Behaviour:
- **Reset** (asynchronous, active-high): every output and internal flop is 0 (valid=0, halted=0, err=0, createdump=0, all data 0). Outputs are 0 while rst is high.
- **Update priority** at each rising clk: flush > stall > load.
- **flush=1:**
  - valid, MemWrite, MemRead, RegWrite and halt-entry all go to 0.
  - Data fields may hold any value; they must not be X.
  - Flush wins over a simultaneous stall.
- **stall=1, flush=0:** all fields hold, including valid.
- **Load** (stall=0, flush=0):
  - Every field captures its ex_* input.
  - valid <= ex_valid & ~halted.
  - Latency is one cycle: EX inputs at edge N appear on the outputs after edge N.
- **Valid gating:**
  - MemWrite, MemRead and RegWrite outputs are the stored bit ANDed with valid.
  - A bubble never writes memory or registers.
- **Halt:**
  - A valid entry with ex_halt sets halted=1 on the same edge it is loaded.
  - halted stays set until reset.
  - While halted=1, all later loads become bubbles (valid=0), so nothing past HALT reaches memory.
  - A flush on the same edge as a HALT load discards the HALT; halted is not set.
- **createdump:**
  - Combinational: valid & halt_entry & ~stall & ~dumped.
  - The internal dumped flop sets on the edge where createdump=1.
  - Result: exactly one pulse per HALT, and it is deferred while stalled.
- **err:**
  - Sticky OR of (ex_err & ex_valid) captured on load edges, OR of the HALT-free case.
  - Never clears except on reset.
  - err does not stop the pipeline.
- **Reset mid-stall or mid-halt:** returns to the reset state immediately. No pulse is emitted on reset release.
- No arithmetic is performed. Widths pass through unchanged.

Decomposition:
- Shared package holds:
  - DATA_W = 16 and REG_W = 3 constants.
  - A struct-equivalent field list for the EX/MEM bundle, reused by the matching MEM/WB register.
- One sub-module is natural: pipe_field_reg. It is a parameterised-width flop with async reset, hold enable and clear-to-zero. It is instantiated per field group, and the stall, flush and valid logic stays in ex_mem_reg.

Test Plan:
- **Reset mid-operation:** load a store (XOut=0x0040, WriteData=0xBEEF, MemWrite=1), then assert rst between edges. All outputs go to 0 immediately, and MemWrite=0 while rst is high.
- **Normal load:** ex_valid=1, ex_MemRead=1, ex_XOut=0x1234, ex_WriteReg=5. After one edge: XOut=0x1234, MemRead=1, WriteReg=5, valid=1.
- **Stall/flush:**
  - Stall for 3 cycles while the EX inputs change to 0xFFFF: outputs hold 0x1234.
  - Assert stall and flush together: the next edge gives valid=0 and MemRead=0.
- **Bubble gating:** ex_valid=0 with ex_MemWrite=1 and ex_RegWrite=1. After the edge, MemWrite=0, RegWrite=0, valid=0.
- **Halt:**
  - Load a valid HALT: halted=1, and createdump=1 for exactly one cycle.
  - Follow with a valid store to 0x0010: valid=0 and MemWrite=0.
  - If stall=1 when the HALT arrives, createdump stays 0 until stall drops, then pulses once.
- **Error:** a valid entry with ex_err=1 sets err=1. It remains 1 after 10 clean instructions and clears only on rst.
